icache_assoc: RTL and testbench
===============================

// Module: icache_assoc
// PURPOSE
//  Parametrised set-associative instruction cache between IF and the memory controller (MC).
//  Hits return the word one cycle after the query; misses fetch a whole block from MC, fill a victim way, then return the word.
//  Adds a flush (fence.i), round-robin replacement and safe discard of in-flight fills on flush.
// PARAMETERS
//  SET_WIDTH    2  log2(number of sets); SETS = 1<<SET_WIDTH
//  WAYS         2  ways per set, >=1 (need not be a power of 2)
//  BLOCK_WIDTH  2  log2(words per block); BLOCK_SIZE = 1<<BLOCK_WIDTH
//  Address split: tag [31:SET_WIDTH+BLOCK_WIDTH+2] | set [SET_WIDTH+BLOCK_WIDTH+1:BLOCK_WIDTH+2] | word [BLOCK_WIDTH+1:2] | 00
// PORTS
//  clk_in          in   1                 single clock, rising edge
//  rst_in          in   1                 reset, asynchronous, active-low
//  rdy_in          in   1                 0 = pause: all state and outputs frozen
//  flush_in        in   1                 invalidate every line
//  IF_query_en     in   1                 IF presents a fetch address this cycle
//  IF_query_addr   in   32                word-aligned fetch address
//  IF_data_out_en  out  1                 one-cycle pulse: IF_data_out valid
//  IF_data_out     out  32                instruction word
//  MC_query_en     out  1                 block request, held high until MC_data_en
//  MC_query_addr   out  32                block-aligned address (low BLOCK_WIDTH+2 bits zero)
//  MC_data_en      in   1                 one-cycle pulse: MC_data valid
//  MC_data         in   32*BLOCK_SIZE     block; word k at [32k+31:32k]
// BEHAVIOUR
//  Reset (rst_in=0, async): state=IDLE, all valid bits 0, RR pointers 0, every output 0.
//  rdy_in=0: no register changes; MC_data_en/flush_in/IF_query_en are ignored (producers hold them).
//  States: IDLE, BUSY (miss outstanding), DRAIN (flushed while BUSY; awaiting MC reply to discard).
//  IDLE, IF_query_en=1, tag match in any valid way of the set: next edge IF_data_out_en=1, word out.
//  IDLE, miss: next edge MC_query_en=1, MC_query_addr=block address, query latched, ->BUSY; no IF output.
//  BUSY: IF_query_en ignored (IF holds until it gets data); MC_query_en/addr held constant.
//  BUSY, MC_data_en=1: write block, tag and valid into the victim way; MC_query_en=0;
//   IF_data_out_en=1 with the latched word at the same edge; ->IDLE. Miss latency = MC latency + 1.
//  Victim: lowest-index invalid way; if all valid, way rr[set]. On every fill, rr[set]<=(way+1)%WAYS.
//  Per-set hit detection checks all WAYS in parallel; more than one matching way cannot occur (fill only on miss).
//  flush_in=1 in IDLE: all valid<=0 next edge; a same-cycle query is dropped (no output, no MC request).
//  flush_in=1 in BUSY: valids cleared; ->DRAIN; MC_query_en held until MC_data_en,
//   then the block is discarded (no fill, no IF output), ->IDLE.
//  flush and MC_data_en in the same BUSY cycle: flush wins. Block discarded, valids cleared, no IF output, ->IDLE.
//  IF_data_out_en is 0 in every cycle not listed above; IF_data_out holds its last value.
// CONFIGURATION
//  ICACHE_STATS_EN defined: extra outputs stat_hit_cnt[31:0] and stat_miss_cnt[31:0].
//   Each +1 per hit/miss query accepted in IDLE; wrap at 2^32; reset to 0; not cleared by flush.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  icache_pkg: state encoding (IDLE/BUSY/DRAIN); localparam functions for TAG_WIDTH and address field slicing.
//  Sub-module icache_victim_sel (per set: valid vector + rr pointer in, victim way index out).
//   Purely combinational; rr registers live in icache_assoc.
//  Storage: data[SETS][WAYS][BLOCK_SIZE], tag[SETS][WAYS], valid[SETS][WAYS] in flops.
// TESTING  (defaults: set bits [5:4], word bits [3:2])
//  Cold miss: query 0x0000_0044 -> next cycle MC_query_en=1, addr 0x0000_0040.
//   MC returns block with word1=0xDEAD_BEEF -> same edge IF_data_out_en=1, data 0xDEAD_BEEF.
//  Hit: re-query 0x0000_0048 -> IF_data_out_en=1 one cycle later, word2, MC_query_en stays 0.
//  Replacement: fill 0x00, 0x40, then 0x80 (all set 0) -> 0x80 replaces way0.
//   0x40 then hits; 0x00 misses with MC_query_addr=0x0000_0000.
//  Flush mid-miss: miss 0x0000_0100, assert flush_in while BUSY -> MC reply produces no IF_data_out_en.
//   Next query 0x0000_0100 misses again.
//  Pause/reset: rdy_in=0 for 5 cycles while BUSY -> MC_query_en/addr unchanged, no output.
//   rst_in=0 mid-BUSY -> all outputs 0 immediately; 0x40 misses afterwards.
//  ICACHE_STATS_EN: 3 misses + 2 hits -> stat_miss_cnt=3, stat_hit_cnt=2; flush leaves both unchanged.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache: controller states
// and helpers that derive address field positions from the cache geometry.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Address layout: tag | set | word | 2'b00
  function automatic int set_lsb(input int block_w);
    return block_w + 2;
  endfunction

  function automatic int tag_lsb(input int set_w, input int block_w);
    return set_w + block_w + 2;
  endfunction

  function automatic int tag_width(input int set_w, input int block_w);
    return 32 - tag_lsb(set_w, block_w);
  endfunction

  // A single-way cache still carries a 1-bit way index so no vector collapses to zero width.
  function automatic int way_index_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// Victim way selection for one set: the lowest-index invalid way wins,
// otherwise the set's round-robin pointer chooses. Purely combinational.
module icache_victim_sel
  import icache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int WAY_W = way_index_width(WAYS)
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [WAY_W-1:0] rr,
  output logic [WAY_W-1:0] victim
);

  // Scanning downwards leaves the lowest invalid index as the final assignment.
  always_comb begin
    victim = rr;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        victim = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache between instruction fetch and the memory controller.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int SET_WIDTH   = 2,
  parameter int WAYS        = 2,
  parameter int BLOCK_WIDTH = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            rdy_in,
  input  logic                            flush_in,
  input  logic                            IF_query_en,
  input  logic [31:0]                     IF_query_addr,
  output logic                            IF_data_out_en,
  output logic [31:0]                     IF_data_out,
`ifdef ICACHE_STATS_EN
  output logic [31:0]                     stat_hit_cnt,
  output logic [31:0]                     stat_miss_cnt,
`endif
  output logic                            MC_query_en,
  output logic [31:0]                     MC_query_addr,
  input  logic                            MC_data_en,
  input  logic [32*(1<<BLOCK_WIDTH)-1:0]  MC_data
);

  localparam int SETS       = 1 << SET_WIDTH;
  localparam int BLOCK_SIZE = 1 << BLOCK_WIDTH;
  localparam int WAY_W      = way_index_width(WAYS);
  localparam int SET_LSB    = set_lsb(BLOCK_WIDTH);
  localparam int TAG_LSB    = tag_lsb(SET_WIDTH, BLOCK_WIDTH);
  localparam int TAG_W      = tag_width(SET_WIDTH, BLOCK_WIDTH);
  localparam logic [31:0] BLOCK_MASK = ~((32'd1 << SET_LSB) - 32'd1);

  state_t state_q, state_d;

  logic [31:0]      data_q  [SETS][WAYS][BLOCK_SIZE];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAY_W-1:0] rr_q    [SETS];

  logic [TAG_W-1:0]       q_tag, m_tag;
  logic [SET_WIDTH-1:0]   q_set, m_set;
  logic [BLOCK_WIDTH-1:0] q_word, m_word;
  logic                   unused_addr_bits;

  logic             hit;
  logic [WAY_W-1:0] hit_way, victim, rr_next;
  logic             do_hit, do_miss, do_fill;

  assign q_tag            = IF_query_addr[31:TAG_LSB];
  assign q_set            = IF_query_addr[TAG_LSB-1:SET_LSB];
  assign q_word           = IF_query_addr[SET_LSB-1:2];
  assign unused_addr_bits = ^IF_query_addr[1:0];

  // All ways of the addressed set are compared at once; at most one can match.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[q_set][w] && (tag_q[q_set][w] == q_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  icache_victim_sel #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_victim_sel (
    .valid  (valid_q[m_set]),
    .rr     (rr_q[m_set]),
    .victim (victim)
  );

  assign rr_next = (victim == WAY_W'(WAYS - 1)) ? '0 : victim + WAY_W'(1);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  // A flush always wins: it drops an IDLE query and turns a pending fill into a discard.
  always_comb begin
    state_d = state_q;
    do_hit  = 1'b0;
    do_miss = 1'b0;
    do_fill = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush_in && IF_query_en) begin
          if (hit) begin
            do_hit = 1'b1;
          end else begin
            do_miss = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (flush_in) begin
          state_d = MC_data_en ? IDLE : DRAIN;
        end else if (MC_data_en) begin
          do_fill = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (MC_data_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      IF_data_out_en <= 1'b0;
      IF_data_out    <= '0;
      MC_query_en    <= 1'b0;
      MC_query_addr  <= '0;
      m_tag          <= '0;
      m_set          <= '0;
      m_word         <= '0;
    end else if (rdy_in) begin
      IF_data_out_en <= do_hit | do_fill;
      if (do_hit) begin
        IF_data_out <= data_q[q_set][hit_way][q_word];
      end else if (do_fill) begin
        IF_data_out <= MC_data[32*m_word +: 32];
      end

      if (do_miss) begin
        MC_query_en   <= 1'b1;
        MC_query_addr <= IF_query_addr & BLOCK_MASK;
        m_tag         <= q_tag;
        m_set         <= q_set;
        m_word        <= q_word;
      end else if (MC_data_en && (state_q != IDLE)) begin
        MC_query_en <= 1'b0;
      end

      if (flush_in) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
        end
      end else if (do_fill) begin
        valid_q[m_set][victim] <= 1'b1;
        rr_q[m_set]            <= rr_next;
      end
    end
  end

  // Line contents need no reset: a line is only ever read while its valid bit is set.
  always_ff @(posedge clk_in) begin
    if (rdy_in && do_fill) begin
      tag_q[m_set][victim] <= m_tag;
      for (int k = 0; k < BLOCK_SIZE; k++) begin
        data_q[m_set][victim][k] <= MC_data[32*k +: 32];
      end
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stat_hit_cnt  <= '0;
      stat_miss_cnt <= '0;
    end else if (rdy_in) begin
      if (do_hit) begin
        stat_hit_cnt <= stat_hit_cnt + 32'd1;
      end
      if (do_miss) begin
        stat_miss_cnt <= stat_miss_cnt + 32'd1;
      end
    end
  end
`else
  // Without statistics the cache carries no counters at all.
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc: directed scenarios plus a randomized fetch stream,
// all compared against a block-address-level model of the cache contents.
module tb_icache_assoc;

  localparam int SET_WIDTH   = 2;
  localparam int WAYS        = 2;
  localparam int BLOCK_WIDTH = 2;
  localparam int SETS        = 1 << SET_WIDTH;
  localparam int BLOCK_SIZE  = 1 << BLOCK_WIDTH;
  localparam int BLOCK_BYTES = BLOCK_SIZE * 4;

  logic                    clk_in = 1'b0;
  logic                    rst_in = 1'b0;
  logic                    rdy_in = 1'b1;
  logic                    flush_in = 1'b0;
  logic                    IF_query_en = 1'b0;
  logic [31:0]             IF_query_addr = '0;
  logic                    IF_data_out_en;
  logic [31:0]             IF_data_out;
  logic                    MC_query_en;
  logic [31:0]             MC_query_addr;
  logic                    MC_data_en = 1'b0;
  logic [32*BLOCK_SIZE-1:0] MC_data = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0]             stat_hit_cnt;
  logic [31:0]             stat_miss_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  // Model: which block addresses each set holds, plus the round-robin pointer.
  bit          mvalid [SETS][WAYS];
  logic [31:0] mblk   [SETS][WAYS];
  int          mrr    [SETS];
  int          model_hits   = 0;
  int          model_misses = 0;

  always #5 clk_in = ~clk_in;

  icache_assoc #(
    .SET_WIDTH   (SET_WIDTH),
    .WAYS        (WAYS),
    .BLOCK_WIDTH (BLOCK_WIDTH)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .flush_in       (flush_in),
    .IF_query_en    (IF_query_en),
    .IF_query_addr  (IF_query_addr),
    .IF_data_out_en (IF_data_out_en),
    .IF_data_out    (IF_data_out),
`ifdef ICACHE_STATS_EN
    .stat_hit_cnt   (stat_hit_cnt),
    .stat_miss_cnt  (stat_miss_cnt),
`endif
    .MC_query_en    (MC_query_en),
    .MC_query_addr  (MC_query_addr),
    .MC_data_en     (MC_data_en),
    .MC_data        (MC_data)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0044) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] blk_of(input logic [31:0] a);
    return a - (a % BLOCK_BYTES);
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a / BLOCK_BYTES) % SETS);
  endfunction

  function automatic logic [32*BLOCK_SIZE-1:0] make_block(input logic [31:0] base);
    logic [32*BLOCK_SIZE-1:0] b;
    for (int k = 0; k < BLOCK_SIZE; k++) b[32*k +: 32] = mem_word(base + 32'(4*k));
    return b;
  endfunction

  function automatic bit model_has(input logic [31:0] a);
    int s = set_of(a);
    for (int w = 0; w < WAYS; w++) if (mvalid[s][w] && mblk[s][w] == blk_of(a)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_fill(input logic [31:0] a);
    int s = set_of(a);
    int v = -1;
    for (int w = 0; w < WAYS; w++) if (!mvalid[s][w] && v < 0) v = w;
    if (v < 0) v = mrr[s];
    mvalid[s][v] = 1'b1;
    mblk[s][v]   = blk_of(a);
    mrr[s]       = (v + 1) % WAYS;
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) mvalid[s][w] = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    for (int s = 0; s < SETS; s++) mrr[s] = 0;
    model_hits   = 0;
    model_misses = 0;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    step();
    step();
    rst_in = 1'b1;
    model_reset();
  endtask

  task automatic do_flush();
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    model_clear();
  endtask

  // One complete fetch; the model decides hit or miss, MC answers after lat cycles.
  task automatic fetch(input logic [31:0] addr, input int lat, output logic saw_hit);
    logic [31:0] exp_w = mem_word(addr);
    bit          hit   = model_has(addr);
    IF_query_en   = 1'b1;
    IF_query_addr = addr;
    step();
    saw_hit = IF_data_out_en;
    if (hit) begin
      model_hits++;
      vectors++;
      if (IF_data_out_en !== 1'b1 || IF_data_out !== exp_w || MC_query_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hit_%h: got en=%b data=%h mc=%b expected en=1 data=%h mc=0",
                 addr, IF_data_out_en, IF_data_out, MC_query_en, exp_w);
      end
      IF_query_en = 1'b0;
    end else begin
      model_misses++;
      for (int c = 0; c < lat; c++) begin
        vectors++;
        if (MC_query_en !== 1'b1 || MC_query_addr !== blk_of(addr) || IF_data_out_en !== 1'b0) begin
          errors++;
          $display("[TB] FAIL miss_req_%h: got mc=%b addr=%h en=%b expected mc=1 addr=%h en=0",
                   addr, MC_query_en, MC_query_addr, IF_data_out_en, blk_of(addr));
        end
        if (c < lat - 1) step();
      end
      MC_data_en = 1'b1;
      MC_data    = make_block(blk_of(addr));
      step();
      MC_data_en  = 1'b0;
      IF_query_en = 1'b0;
      vectors++;
      if (IF_data_out_en !== 1'b1 || IF_data_out !== exp_w || MC_query_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fill_%h: got en=%b data=%h mc=%b expected en=1 data=%h mc=0",
                 addr, IF_data_out_en, IF_data_out, MC_query_en, exp_w);
      end
      model_fill(addr);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    step();
    vectors++;
    if ({IF_data_out_en, MC_query_en} !== 2'b00 || IF_data_out !== 32'h0 || MC_query_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got en=%b mc=%b data=%h addr=%h expected all 0",
               IF_data_out_en, MC_query_en, IF_data_out, MC_query_addr);
    end
    rst_in = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_cold_miss();
    logic h;
    fetch(32'h0000_0044, 3, h);
    vectors++;
    if (h !== 1'b0 || IF_data_out !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL cold_miss: got hit=%b data=%h expected hit=0 data=deadbeef", h, IF_data_out);
    end
  endtask

  task automatic test_hit();
    logic h;
    fetch(32'h0000_0048, 1, h);
    vectors++;
    if (h !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hit_0x48: got hit=%b expected 1", h);
    end
    step();
    vectors++;
    if (IF_data_out_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pulse_width: got en=%b expected 0", IF_data_out_en);
    end
  endtask

  task automatic test_replacement();
    logic h;
    do_flush();
    fetch(32'h0000_0000, 2, h);
    fetch(32'h0000_0040, 2, h);
    fetch(32'h0000_0080, 2, h);
    fetch(32'h0000_0040, 1, h);
    vectors++;
    if (h !== 1'b1) begin
      errors++;
      $display("[TB] FAIL repl_0x40_hit: got hit=%b expected 1", h);
    end
    fetch(32'h0000_0000, 2, h);
    vectors++;
    if (h !== 1'b0) begin
      errors++;
      $display("[TB] FAIL repl_0x00_miss: got hit=%b expected 0", h);
    end
  endtask

  task automatic test_back_to_back();
    logic h;
    fetch(32'h0000_0040, 2, h);
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      IF_query_en   = 1'b1;
      IF_query_addr = 32'h40 + 32'(4*i);
      step();
      model_hits++;
      vectors++;
      if (IF_data_out_en !== 1'b1 || IF_data_out !== mem_word(32'h40 + 32'(4*i))) begin
        errors++;
        $display("[TB] FAIL b2b_%0d: got en=%b data=%h expected en=1 data=%h",
                 i, IF_data_out_en, IF_data_out, mem_word(32'h40 + 32'(4*i)));
      end
    end
    IF_query_en = 1'b0;
    step();
  endtask

  task automatic test_flush_idle();
    logic h;
    IF_query_en   = 1'b1;
    IF_query_addr = 32'h0000_0044;
    flush_in      = 1'b1;
    step();
    flush_in    = 1'b0;
    IF_query_en = 1'b0;
    model_clear();
    vectors++;
    if (IF_data_out_en !== 1'b0 || MC_query_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_idle_drop: got en=%b mc=%b expected 0 0", IF_data_out_en, MC_query_en);
    end
    fetch(32'h0000_0044, 1, h);
    vectors++;
    if (h !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_idle_refetch: got hit=%b expected 0", h);
    end
  endtask

  task automatic test_flush_mid_miss();
    logic h;
    IF_query_en   = 1'b1;
    IF_query_addr = 32'h0000_0100;
    step();
    model_misses++;
    step();
    flush_in    = 1'b1;
    IF_query_en = 1'b0;
    step();
    flush_in = 1'b0;
    model_clear();
    step();
    vectors++;
    if (MC_query_en !== 1'b1 || MC_query_addr !== 32'h0000_0100) begin
      errors++;
      $display("[TB] FAIL drain_hold: got mc=%b addr=%h expected 1 00000100", MC_query_en, MC_query_addr);
    end
    MC_data_en = 1'b1;
    MC_data    = make_block(32'h0000_0100);
    step();
    MC_data_en = 1'b0;
    vectors++;
    if (IF_data_out_en !== 1'b0 || MC_query_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_discard: got en=%b mc=%b expected 0 0", IF_data_out_en, MC_query_en);
    end
    fetch(32'h0000_0100, 2, h);
    vectors++;
    if (h !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_refetch: got hit=%b expected 0", h);
    end
  endtask

  task automatic test_flush_with_reply();
    logic h;
    IF_query_en   = 1'b1;
    IF_query_addr = 32'h0000_5000;
    step();
    model_misses++;
    MC_data_en  = 1'b1;
    MC_data     = make_block(32'h0000_5000);
    flush_in    = 1'b1;
    IF_query_en = 1'b0;
    step();
    MC_data_en = 1'b0;
    flush_in   = 1'b0;
    model_clear();
    vectors++;
    if (IF_data_out_en !== 1'b0 || MC_query_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_reply_same: got en=%b mc=%b expected 0 0", IF_data_out_en, MC_query_en);
    end
    fetch(32'h0000_5000, 1, h);
    vectors++;
    if (h !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_reply_refetch: got hit=%b expected 0", h);
    end
  endtask

  task automatic test_pause();
    IF_query_en   = 1'b1;
    IF_query_addr = 32'h0000_71C4;
    step();
    model_misses++;
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (MC_query_en !== 1'b1 || MC_query_addr !== 32'h0000_71C0 || IF_data_out_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL pause_%0d: got mc=%b addr=%h en=%b expected 1 000071c0 0",
                 i, MC_query_en, MC_query_addr, IF_data_out_en);
      end
    end
    rdy_in     = 1'b1;
    MC_data_en = 1'b1;
    MC_data    = make_block(32'h0000_71C0);
    step();
    MC_data_en  = 1'b0;
    IF_query_en = 1'b0;
    model_fill(32'h0000_71C4);
    vectors++;
    if (IF_data_out_en !== 1'b1 || IF_data_out !== mem_word(32'h0000_71C4)) begin
      errors++;
      $display("[TB] FAIL pause_resume: got en=%b data=%h expected 1 %h",
               IF_data_out_en, IF_data_out, mem_word(32'h0000_71C4));
    end
  endtask

  task automatic test_reset_mid_busy();
    logic h;
    IF_query_en   = 1'b1;
    IF_query_addr = 32'h0000_3000;
    step();
    #2;
    rst_in = 1'b0;
    #1;
    vectors++;
    if ({IF_data_out_en, MC_query_en} !== 2'b00 || IF_data_out !== 32'h0 || MC_query_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_reset: got en=%b mc=%b data=%h addr=%h expected all 0",
               IF_data_out_en, MC_query_en, IF_data_out, MC_query_addr);
    end
    IF_query_en = 1'b0;
    step();
    rst_in = 1'b1;
    model_reset();
    step();
    fetch(32'h0000_0040, 2, h);
    vectors++;
    if (h !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_refetch: got hit=%b expected 0", h);
    end
  endtask

  task automatic test_random();
    logic h;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) do_flush();
      fetch(32'($urandom_range(0, 63)) << 2, int'($urandom_range(1, 4)), h);
    end
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    logic h;
    vectors++;
    if (stat_hit_cnt !== 32'(model_hits) || stat_miss_cnt !== 32'(model_misses)) begin
      errors++;
      $display("[TB] FAIL stats_running: got %0d/%0d expected %0d/%0d",
               stat_hit_cnt, stat_miss_cnt, model_hits, model_misses);
    end
    do_reset();
    fetch(32'h0000_1000, 1, h);
    fetch(32'h0000_2000, 1, h);
    fetch(32'h0000_3000, 1, h);
    fetch(32'h0000_2000, 1, h);
    fetch(32'h0000_3004, 1, h);
    do_flush();
    step();
    vectors++;
    if (stat_hit_cnt !== 32'd2 || stat_miss_cnt !== 32'd3) begin
      errors++;
      $display("[TB] FAIL stats_3m2h: got hits=%0d misses=%0d expected 2 3", stat_hit_cnt, stat_miss_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_replacement();
    test_back_to_back();
    test_flush_idle();
    test_flush_mid_miss();
    test_flush_with_reply();
    test_pause();
    test_reset_mid_busy();
    test_random();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
